// File: rtl/cmp_search_ctrl_pkg.sv
// Shared types for the binary-search controller that drives a magnitude comparator.
package cmp_search_ctrl_pkg;

    typedef enum logic {
        IDLE,
        SEARCH
    } state_e;

    typedef enum logic [1:0] {
        FLAG_LT,
        FLAG_GT,
        FLAG_EQ,
        FLAG_BAD
    } flag_e;

    // Exactly one comparator flag must be high; anything else is a protocol error.
    function automatic flag_e decode_flags(input logic lt, input logic gt, input logic eq);
        flag_e f;
        case ({lt, gt, eq})
            3'b100:  f = FLAG_LT;
            3'b010:  f = FLAG_GT;
            3'b001:  f = FLAG_EQ;
            default: f = FLAG_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/cmp_search_ctrl.sv
// Binary-search controller: drives probe onto comparator B, narrows [lo,hi]
// from the returned flags and reports the located value or a protocol error.
module cmp_search_ctrl
    import cmp_search_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAXV  = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             A_lt_B,
    input  logic             A_gt_B,
    input  logic             A_eq_B,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] probe_cnt
);

    localparam logic [WIDTH:0] MAXV_W = (WIDTH+1)'(MAXV);
    localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);

    state_e           state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d;
    logic [WIDTH-1:0] probe_q, probe_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    flag_e            flag;
    logic [WIDTH:0]   nlo, nhi;
    logic             narrow;

    // Extra top bit keeps lo+hi from wrapping before the halving shift.
    function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] l, input logic [WIDTH:0] h);
        logic [WIDTH+1:0] s;
        s = {1'b0, l} + {1'b0, h};
        return s[WIDTH:1];
    endfunction

    // hi below zero shows up as the sign bit of the WIDTH+1-bit value.
    function automatic logic range_empty(input logic [WIDTH:0] l, input logic [WIDTH:0] h);
        return h[WIDTH] || (l > h);
    endfunction

    assign flag = decode_flags(A_lt_B, A_gt_B, A_eq_B);

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probe_d  = probe_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;
        done_d   = 1'b0;
        nlo      = lo_q;
        nhi      = hi_q;
        narrow   = 1'b0;

        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped on purpose.
                if (start && !done_q) begin
                    lo_d    = '0;
                    hi_d    = MAXV_W;
                    probe_d = midpoint('0, MAXV_W);
                    cnt_d   = WIDTH'(1);
                    found_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                case (flag)
                    FLAG_EQ: begin
                        result_d = probe_q;
                        found_d  = 1'b1;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                    FLAG_LT: begin
                        nhi    = {1'b0, probe_q} - ONE_W;
                        narrow = 1'b1;
                    end
                    FLAG_GT: begin
                        nlo    = {1'b0, probe_q} + ONE_W;
                        narrow = 1'b1;
                    end
                    default: begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                endcase

                if (narrow) begin
                    lo_d = nlo;
                    hi_d = nhi;
                    if (range_empty(nlo, nhi)) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        probe_d = midpoint(nlo, nhi);
                        cnt_d   = cnt_q + WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            probe_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probe_q  <= probe_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign probe     = probe_q;
    assign busy      = (state_q == SEARCH);
    assign done      = done_q;
    assign found     = found_q;
    assign err       = err_q;
    assign result    = result_q;
    assign probe_cnt = cnt_q;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench: behavioural 4-bit comparator closes the loop around the controller.
module tb_cmp_search_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       A_lt_B, A_gt_B, A_eq_B;
    logic [3:0] probe;
    logic       busy, done, found, err;
    logic [3:0] result;
    logic [3:0] probe_cnt;

    logic [3:0] target;
    logic       frc_en;
    logic [2:0] frc_val;
    logic [3:0] exp_seq [5];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (frc_en) begin
            {A_lt_B, A_gt_B, A_eq_B} = frc_val;
        end else begin
            A_lt_B = (target < probe);
            A_gt_B = (target > probe);
            A_eq_B = (target == probe);
        end
    end

    cmp_search_ctrl #(.WIDTH(4), .MAXV(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A_lt_B    (A_lt_B),
        .A_gt_B    (A_gt_B),
        .A_eq_B    (A_eq_B),
        .probe     (probe),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .err       (err),
        .result    (result),
        .probe_cnt (probe_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a search and follow it to the done pulse; exp_seq holds the probes.
    task automatic do_search(input string nm, input logic [3:0] tgt, input int n,
                             input bit hold_start);
        target = tgt;
        start  = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        chk({nm, "_busy0"}, {7'd0, busy}, 8'd1);
        chk({nm, "_found0"}, {7'd0, found}, 8'd0);
        chk({nm, "_cnt0"}, {4'd0, probe_cnt}, 8'd1);
        chk({nm, "_p0"}, {4'd0, probe}, {4'd0, exp_seq[0]});
        for (int k = 1; k < n; k++) begin
            step();
            chk($sformatf("%s_p%0d", nm, k), {4'd0, probe}, {4'd0, exp_seq[k]});
            chk($sformatf("%s_nodone%0d", nm, k), {7'd0, done}, 8'd0);
        end
        step();
        chk({nm, "_done"}, {7'd0, done}, 8'd1);
        chk({nm, "_found"}, {7'd0, found}, 8'd1);
        chk({nm, "_err"}, {7'd0, err}, 8'd0);
        chk({nm, "_busy"}, {7'd0, busy}, 8'd0);
        chk({nm, "_result"}, {4'd0, result}, {4'd0, tgt});
        chk({nm, "_cnt"}, {4'd0, probe_cnt}, n[7:0]);
        // start still high here when held: the done cycle must not accept it
        step();
        start = 1'b0;
        chk({nm, "_pulse"}, {7'd0, done}, 8'd0);
        chk({nm, "_idle"}, {7'd0, busy}, 8'd0);
        chk({nm, "_hold"}, {4'd0, probe}, {4'd0, exp_seq[n-1]});
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        target  = 4'h0;
        frc_en  = 1'b0;
        frc_val = 3'b000;
        repeat (2) step();
        chk("rst_probe", {4'd0, probe}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_found", {7'd0, found}, 8'd0);
        chk("rst_err", {7'd0, err}, 8'd0);
        chk("rst_cnt", {4'd0, probe_cnt}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_busy", {7'd0, busy}, 8'd0);

        exp_seq[0] = 4'd7;
        do_search("t7", 4'h7, 1, 1'b0);

        exp_seq[0] = 4'd7; exp_seq[1] = 4'd3; exp_seq[2] = 4'd1; exp_seq[3] = 4'd0;
        do_search("t0", 4'h0, 4, 1'b0);

        exp_seq[0] = 4'd7; exp_seq[1] = 4'd11; exp_seq[2] = 4'd13;
        exp_seq[3] = 4'd14; exp_seq[4] = 4'd15;
        do_search("tF", 4'hF, 5, 1'b0);

        exp_seq[0] = 4'd7; exp_seq[1] = 4'd11; exp_seq[2] = 4'd9; exp_seq[3] = 4'd10;
        do_search("tA", 4'hA, 4, 1'b0);

        exp_seq[0] = 4'd7; exp_seq[1] = 4'd11; exp_seq[2] = 4'd9;
        do_search("t9", 4'h9, 3, 1'b0);

        // start held high throughout: sequence for 0xA must be unchanged
        exp_seq[0] = 4'd7; exp_seq[1] = 4'd11; exp_seq[2] = 4'd9; exp_seq[3] = 4'd10;
        do_search("hold", 4'hA, 4, 1'b1);

        // no flags at all on the first probe
        frc_en  = 1'b1;
        frc_val = 3'b000;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("f000_busy", {7'd0, busy}, 8'd1);
        step();
        chk("f000_done", {7'd0, done}, 8'd1);
        chk("f000_err", {7'd0, err}, 8'd1);
        chk("f000_found", {7'd0, found}, 8'd0);
        chk("f000_probe", {4'd0, probe}, 8'd7);
        chk("f000_cnt", {4'd0, probe_cnt}, 8'd1);
        step();

        // two flags at once
        frc_val = 3'b110;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("f110_err_clr", {7'd0, err}, 8'd0);
        step();
        chk("f110_done", {7'd0, done}, 8'd1);
        chk("f110_err", {7'd0, err}, 8'd1);
        chk("f110_found", {7'd0, found}, 8'd0);
        chk("f110_probe", {4'd0, probe}, 8'd7);
        step();

        // always "less than": range collapses below zero after probe 0
        frc_val = 3'b100;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("flt_p0", {4'd0, probe}, 8'd7);
        step();
        chk("flt_p1", {4'd0, probe}, 8'd3);
        step();
        chk("flt_p2", {4'd0, probe}, 8'd1);
        step();
        chk("flt_p3", {4'd0, probe}, 8'd0);
        chk("flt_nodone", {7'd0, done}, 8'd0);
        step();
        chk("flt_done", {7'd0, done}, 8'd1);
        chk("flt_err", {7'd0, err}, 8'd1);
        chk("flt_found", {7'd0, found}, 8'd0);
        chk("flt_cnt", {4'd0, probe_cnt}, 8'd4);
        chk("flt_busy", {7'd0, busy}, 8'd0);
        step();
        frc_en = 1'b0;

        // asynchronous reset in the middle of a search for 0xF
        target = 4'hF;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("ar_p1", {4'd0, probe}, 8'd11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_probe", {4'd0, probe}, 8'd0);
        chk("ar_busy", {7'd0, busy}, 8'd0);
        chk("ar_cnt", {4'd0, probe_cnt}, 8'd0);
        chk("ar_result", {4'd0, result}, 8'd0);
        chk("ar_found", {7'd0, found}, 8'd0);
        step();
        chk("ar_nodone", {7'd0, done}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ar_after_done", {7'd0, done}, 8'd0);
        chk("ar_after_busy", {7'd0, busy}, 8'd0);
        chk("ar_after_err", {7'd0, err}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cmp_search_ctrl.md
Name: cmp_search_ctrl

Overview:
- Sequential controller that sits on the B side and the flag outputs of the team's 4-bit magnitude comparator (A_lt_B, A_gt_B, A_eq_B).
- Finds an unknown value held on the comparator's A input by binary search.
- Each cycle it drives a probe onto B, samples the three flags and narrows the search range.
- Reports the located value, the number of probes taken and a protocol error.

Parameters:
- WIDTH, 4: width of probe and result. It must match the comparator width.
- MAXV, 2**WIDTH-1: upper bound of the initial search range.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a search; sampled only in IDLE
- A_lt_B  input  1  comparator flag: target < probe
- A_gt_B  input  1  comparator flag: target > probe
- A_eq_B  input  1  comparator flag: target == probe
- probe  output  WIDTH  value driven to comparator B input (registered)
- busy  output  1  high while state is SEARCH
- done  output  1  one-cycle pulse when the search terminates (found or error)
- found  output  1  last search located the target; held until next start
- err  output  1  last search hit a protocol error; held until next start
- result  output  WIDTH  located value; valid when found is 1
- probe_cnt  output  WIDTH  probes used by the last or current search

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0 and state is IDLE. Reset mid-search aborts immediately. No done pulse is produced.
- States:
  - IDLE: waits for start.
  - SEARCH: samples the flags at every rising edge.
  - No separate DONE state; termination returns to IDLE and pulses done.
- IDLE with start=1 at an edge:
  - lo=0, hi=MAXV, probe=(lo+hi)>>1 = 7 for WIDTH=4.
  - probe_cnt=1, found=0, err=0, busy=1.
  - Go to SEARCH.
- IDLE with start=0: all registers hold. done=0.
- SEARCH, one edge per probe, flags sampled against the currently registered probe:
  - Exactly A_eq_B: result=probe, found=1, done=1, busy=0, go to IDLE.
  - Exactly A_lt_B: hi=probe-1.
  - Exactly A_gt_B: lo=probe+1.
  - After a narrowing step: if lo>hi, set err=1, done=1, busy=0, go to IDLE. Otherwise probe=(lo+hi)>>1, probe_cnt+1, stay in SEARCH.
  - Zero flags or more than one flag high: err=1, done=1, busy=0, go to IDLE. probe, result and probe_cnt hold.
- Width rules:
  - lo and hi are WIDTH+1 bits wide, so probe-1 at probe=0 gives -1 without wrap and probe+1 at MAXV gives MAXV+1.
  - The lo>hi comparison is unsigned on the WIDTH+1-bit value, with hi=-1 decoded as empty.
  - The midpoint sum is computed in WIDTH+2 bits.
- Latency: done rises N edges after the start edge, where N = probe_cnt. Worst case for WIDTH=4 is N=5. A correct comparator with a static target always terminates with found=1 within WIDTH+1 probes.
- start while busy is ignored.
- start in the same cycle that done pulses is not accepted; it must be re-asserted in IDLE.
- probe holds its last value in IDLE.
- The target on A must be static during SEARCH. If it changes, the only guarantee is termination, with found or err.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SEARCH}
  - a flag-decode function returning {LT, GT, EQ, BAD} from the three flags
- No sub-module inside the block.
- The bench instantiates the existing comparator with A = target register, B = probe, and wires its three flags back.

Test Plan:
- Target 0x7, start pulse: probes 7; done one edge after start; found=1, result=7, probe_cnt=1.
- Target 0x0: probes 7,3,1,0; done after 4 edges; result=0, probe_cnt=4.
- Target 0xF: probes 7,11,13,14,15; probe_cnt=5, result=F, err=0.
- Target 0xA: probes 7,11,9,10; probe_cnt=4. Then target 0x9 with a new start: found clears on the start edge; probes 7,11,9; result=9.
- Faults, each a separate run:
  - Flags forced to 000 on the first probe: done and err=1 one edge after start, found=0, probe=7.
  - Flags forced to 110: same response.
  - Flags forced to always-lt: probes 7,3,1,0, then lo>hi gives err=1, probe_cnt=4.
- Reset and start handling:
  - rst_n pulsed low during SEARCH (target 0xF, after probe 11): all outputs 0 immediately and no done.
  - start asserted during busy: ignored, probe sequence unchanged.
